// File: rtl/minimax_uart_pkg.sv
// Shared definitions for the minimax UART transmitter: serializer states,
// register offsets and STATUS layout.
package minimax_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic [31:0] TXDATA_OFS = 32'h0;
    localparam logic [31:0] STATUS_OFS = 32'h4;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;
    localparam int STAT_CNT_W   = 7;

    function automatic logic [31:0] status_word(
        input logic                  full,
        input logic                  empty,
        input logic                  busy,
        input logic                  ovf,
        input logic [STAT_CNT_W-1:0] cnt
    );
        logic [31:0] w;
        w                             = '0;
        w[STAT_FULL]                  = full;
        w[STAT_EMPTY]                 = empty;
        w[STAT_BUSY]                  = busy;
        w[STAT_OVF]                   = ovf;
        w[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/minimax_sync_fifo.sv
// Single-clock FIFO with a first-word-fall-through head; push is refused when
// full and pop is refused when empty.
module minimax_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Fullness is judged on the registered count, so a pop in the same cycle
    // never makes room for a push to a full FIFO.
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/minimax_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register window, transmit
// FIFO and a start/data/stop serializer driving a registered txd.
module minimax_uart_tx
    import minimax_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hfffffff0,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        rreq,
    output logic [31:0] rdata,
    output logic        txd
);

    localparam logic [31:0] TX_ADDR = BASE_ADDR + TXDATA_OFS;
    localparam logic [31:0] ST_ADDR = BASE_ADDR + STATUS_OFS;
    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int          BW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          txd_q;
    logic          ovf_q, ovf_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          wr_tx, clr_ovf, rd_st, ovf_set;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;
    logic          unused_bits;

    assign unused_bits = ^{wdata[31:8], wmask[3:1]};

    assign wr_tx    = (addr == TX_ADDR) && wmask[0];
    assign clr_ovf  = (addr == ST_ADDR) && wmask[0] && wdata[STAT_OVF];
    assign rd_st    = (addr == ST_ADDR) && rreq;
    assign ovf_set  = wr_tx && fifo_full;
    assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

    minimax_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr_tx),
        .wdata_i (wdata[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign status = status_word(fifo_full, fifo_empty, state_q != ST_IDLE, ovf_q,
                                STAT_CNT_W'(fifo_count));

    // A fresh overflow wins over a clear landing on the same edge.
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;
        rdata_d = rd_st ? status : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
        end
    end

    // Serializer; txd_q is updated on the same edge that enters each bit so
    // the line changes exactly at bit boundaries.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    txd_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q <= fifo_head;
                        baud_q  <= BAUD_RELOAD;
                        txd_q   <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_q == '0) begin
                        baud_q  <= BAUD_RELOAD;
                        bit_q   <= '0;
                        txd_q   <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        baud_q <= baud_q - BW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_q == '0) begin
                        baud_q <= BAUD_RELOAD;
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - BW'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        baud_q <= baud_q - BW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign txd   = txd_q;
    assign rdata = rdata_q;

endmodule
